// File: rtl/msp430_pkg.sv
// Shared definitions for the MSP430 register file slice.
// Contents: register indices (PC, SP, SR, CG), As addressing-mode encodings,
// SR status-bit positions and the constant-generator result record.
package msp430_pkg;

  // Register indices
  localparam logic [3:0] REG_PC = 4'd0;
  localparam logic [3:0] REG_SP = 4'd1;
  localparam logic [3:0] REG_SR = 4'd2;
  localparam logic [3:0] REG_CG = 4'd3;

  // As addressing-mode encodings
  localparam logic [1:0] AS_REG = 2'b00;
  localparam logic [1:0] AS_IDX = 2'b01;
  localparam logic [1:0] AS_IND = 2'b10;
  localparam logic [1:0] AS_INC = 2'b11;

  // SR status-bit positions
  localparam logic [3:0] SR_C = 4'd0;
  localparam logic [3:0] SR_Z = 4'd1;
  localparam logic [3:0] SR_N = 4'd2;
  localparam logic [3:0] SR_V = 4'd8;

  // Constant-generator decode result
  typedef struct packed {
    logic        is_const;
    logic        absolute;
    logic [15:0] value;
  } cg_t;

endpackage

// File: rtl/regfile_unit_if.sv
// Sequencer <-> register-file control/operand bundle.
// master: instruction sequencer (drives control lines, reads results).
// slave : register file (reads control lines, drives operand/addr/status).
//   bytemode, As, regno, reg_store, reg_inc, wr_data, flags_we, flags_in : control
//   operand, addr, use_mem, is_const, pc, sr                              : results
interface regfile_unit_if;
  logic        bytemode;
  logic [1:0]  As;
  logic [3:0]  regno;
  logic        reg_store;
  logic        reg_inc;
  logic [15:0] wr_data;
  logic        flags_we;
  logic [3:0]  flags_in;
  logic [15:0] operand;
  logic [15:0] addr;
  logic        use_mem;
  logic        is_const;
  logic [15:0] pc;
  logic [15:0] sr;

  modport master (
    output bytemode, As, regno, reg_store, reg_inc, wr_data, flags_we, flags_in,
    input  operand, addr, use_mem, is_const, pc, sr
  );

  modport slave (
    input  bytemode, As, regno, reg_store, reg_inc, wr_data, flags_we, flags_in,
    output operand, addr, use_mem, is_const, pc, sr
  );
endinterface

// File: rtl/regfile_unit_const_gen.sv
// const_gen: combinational MSP430 constant-generator decode.
// Ports:
//   regno    in  4  selected register
//   as_mode  in  2  addressing mode
//   bytemode in  1  byte operation (masks the all-ones constant)
//   cg       out    {is_const, absolute, value}
// R2 As=01 is absolute mode (address 0 from memory), not a constant.
module const_gen
  import msp430_pkg::*;
(
  input  logic [3:0] regno,
  input  logic [1:0] as_mode,
  input  logic       bytemode,
  output cg_t        cg
);

  always_comb begin
    cg = '0;
    if (regno == REG_SR) begin
      case (as_mode)
        AS_IDX: cg.absolute = 1'b1;
        AS_IND: begin
          cg.is_const = 1'b1;
          cg.value    = 16'd4;
        end
        AS_INC: begin
          cg.is_const = 1'b1;
          cg.value    = 16'd8;
        end
        default: ;
      endcase
    end else if (regno == REG_CG) begin
      cg.is_const = 1'b1;
      case (as_mode)
        AS_REG:  cg.value = 16'h0000;
        AS_IDX:  cg.value = 16'h0001;
        AS_IND:  cg.value = 16'h0002;
        default: cg.value = bytemode ? 16'h00FF : 16'hFFFF;
      endcase
    end
  end

endmodule

// File: rtl/regfile_unit.sv
// regfile_unit: MSP430 register file R0-R15 with operand/address responder.
// Ports:
//   clk  in  system clock, state updates on rising edge
//   srst in  asynchronous active-high reset
//   bus  slave modport of regfile_unit_if (control in, operand/addr/status out)
// Parameters: RESET_PC, RESET_SP - R0/R1 reset values.
// Build option: define REGFILE_CG_EN to enable the constant generator, R2
// absolute mode and discarding of R3 writes. Without it R2/R3 are ordinary.
module regfile_unit
  import msp430_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] RESET_SP = 16'h0000
) (
  input logic           clk,
  input logic           srst,
  regfile_unit_if.slave bus
);

`ifdef REGFILE_CG_EN
  localparam bit CgEn = 1'b1;
`else
  localparam bit CgEn = 1'b0;
`endif

  logic [15:0] regs_q [16];
  logic [15:0] regs_d [16];

  cg_t         cg_raw;
  logic        cg_const;
  logic        cg_abs;
  logic [15:0] sel_q;
  logic [15:0] wr_val;
  logic [15:0] inc_val;
  logic        inc_two;
  logic        store_en;

  const_gen u_const_gen (
    .regno    (bus.regno),
    .as_mode  (bus.As),
    .bytemode (bus.bytemode),
    .cg       (cg_raw)
  );

  assign cg_const = CgEn & cg_raw.is_const;
  assign cg_abs   = CgEn & cg_raw.absolute;
  assign sel_q    = regs_q[bus.regno];

  // Read path
  always_comb begin
    bus.is_const = cg_const;
    bus.use_mem  = ~cg_const & (bus.As != AS_REG);
    bus.addr     = cg_abs ? 16'h0000 : sel_q;
    if (cg_const) begin
      bus.operand = cg_raw.value;
    end else if (bus.bytemode) begin
      bus.operand = {8'h00, sel_q[7:0]};
    end else begin
      bus.operand = sel_q;
    end
    bus.pc = regs_q[REG_PC];
    bus.sr = regs_q[REG_SR];
  end

  // Next state: increment, then flags, then store, so later stages win.
  always_comb begin
    regs_d  = regs_q;
    // PC/SP stay word aligned even for byte accesses.
    inc_two = (bus.regno == REG_PC) || (bus.regno == REG_SP) || !bus.bytemode;
    inc_val = sel_q + (inc_two ? 16'd2 : 16'd1);
    wr_val  = bus.bytemode ? {8'h00, bus.wr_data[7:0]} : bus.wr_data;
    if ((bus.regno == REG_PC) || (bus.regno == REG_SP)) begin
      wr_val[0] = 1'b0;
    end
    store_en = bus.reg_store && !(CgEn && (bus.regno == REG_CG));

    if (bus.reg_inc && !cg_const) begin
      regs_d[bus.regno] = inc_val;
    end
    if (bus.flags_we) begin
      regs_d[REG_SR][SR_C] = bus.flags_in[0];
      regs_d[REG_SR][SR_Z] = bus.flags_in[1];
      regs_d[REG_SR][SR_N] = bus.flags_in[2];
      regs_d[REG_SR][SR_V] = bus.flags_in[3];
    end
    if (store_en) begin
      regs_d[bus.regno] = wr_val;
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= (i == 0) ? RESET_PC : ((i == 1) ? RESET_SP : 16'h0000);
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_unit.sv
// Bench for regfile_unit: directed vector table, constant-generator corner
// sequence, randomized traffic against a behavioural register model, and an
// asynchronous mid-cycle reset.
module tb_regfile_unit;
  import msp430_pkg::*;

  localparam logic [15:0] RST_PC = 16'hF000;
  localparam logic [15:0] RST_SP = 16'h0400;
`ifdef REGFILE_CG_EN
  localparam bit CG_EN = 1'b1;
`else
  localparam bit CG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  regfile_unit_if bus ();

  regfile_unit #(
    .RESET_PC (RST_PC),
    .RESET_SP (RST_SP)
  ) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] mreg [16];

  typedef struct {
    logic [3:0]  n;
    logic [1:0]  a;
    logic        bm;
    logic        st;
    logic        inc;
    logic [15:0] wd;
    logic        fwe;
    logic [3:0]  fin;
    logic        e_mem;
    logic [15:0] e_val;   // addr when e_mem, else operand
    logic [15:0] e_pc;
    logic [15:0] e_sr;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = 16'h0000;
    mreg[0] = RST_PC;
    mreg[1] = RST_SP;
  endtask

  function automatic bit m_const(input logic [3:0] n, input logic [1:0] a);
    return CG_EN && ((n == 4'd3) || ((n == 4'd2) && (a >= 2'd2)));
  endfunction

  function automatic logic [15:0] m_const_val(input logic [3:0] n, input logic [1:0] a,
                                              input logic bm);
    if (n == 4'd2) return (a == 2'd3) ? 16'd8 : 16'd4;
    if (a == 2'd3) return bm ? 16'h00FF : 16'hFFFF;
    return {14'd0, a};
  endfunction

  task automatic drive(input logic [3:0] n, input logic [1:0] a, input logic bm,
                       input logic st, input logic inc, input logic [15:0] wd,
                       input logic fwe, input logic [3:0] fin);
    bus.regno     = n;
    bus.As        = a;
    bus.bytemode  = bm;
    bus.reg_store = st;
    bus.reg_inc   = inc;
    bus.wr_data   = wd;
    bus.flags_we  = fwe;
    bus.flags_in  = fin;
  endtask

  // Apply the architectural rules for one clock edge to the model.
  task automatic model_edge();
    logic [15:0] nxt [16];
    logic [3:0]  n;
    logic [15:0] v;
    n   = bus.regno;
    nxt = mreg;
    if (bus.reg_inc && !m_const(n, bus.As))
      nxt[n] = mreg[n] + (((n < 4'd2) || !bus.bytemode) ? 16'd2 : 16'd1);
    if (bus.flags_we) begin
      nxt[2][0] = bus.flags_in[0];
      nxt[2][1] = bus.flags_in[1];
      nxt[2][2] = bus.flags_in[2];
      nxt[2][8] = bus.flags_in[3];
    end
    if (bus.reg_store && !(CG_EN && (n == 4'd3))) begin
      v = bus.bytemode ? {8'h00, bus.wr_data[7:0]} : bus.wr_data;
      if (n < 4'd2) v[0] = 1'b0;
      nxt[n] = v;
    end
    mreg = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    logic [3:0] n;
    logic [1:0] a;
    bit         cst;
    bit         abs_m;
    n     = bus.regno;
    a     = bus.As;
    cst   = m_const(n, a);
    abs_m = CG_EN && (n == 4'd2) && (a == 2'd1);
    check({tag, ".is_const"}, {15'd0, bus.is_const}, {15'd0, cst});
    check({tag, ".use_mem"}, {15'd0, bus.use_mem}, {15'd0, (!cst && (a != 2'd0))});
    if (!cst && (a != 2'd0))
      check({tag, ".addr"}, bus.addr, abs_m ? 16'h0000 : mreg[n]);
    else if (cst)
      check({tag, ".operand"}, bus.operand, m_const_val(n, a, bus.bytemode));
    else
      check({tag, ".operand"}, bus.operand,
            bus.bytemode ? {8'h00, mreg[n][7:0]} : mreg[n]);
    check({tag, ".pc"}, bus.pc, mreg[0]);
    check({tag, ".sr"}, bus.sr, mreg[2]);
  endtask

  initial begin
    //          n  a  bm st in wd        fwe fin    mem val       pc        sr
    tbl[0]  = '{0, 3, 0, 0, 1, 16'h0000, 0, 4'h0,  1, 16'hF000, 16'hF000, 16'h0000};
    tbl[1]  = '{5, 0, 0, 1, 0, 16'h1234, 0, 4'h0,  0, 16'h0000, 16'hF002, 16'h0000};
    tbl[2]  = '{5, 3, 1, 0, 1, 16'h0000, 0, 4'h0,  1, 16'h1234, 16'hF002, 16'h0000};
    tbl[3]  = '{5, 0, 0, 0, 0, 16'h0000, 0, 4'h0,  0, 16'h1235, 16'hF002, 16'h0000};
    tbl[4]  = '{5, 0, 1, 1, 0, 16'hABCD, 0, 4'h0,  0, 16'h0035, 16'hF002, 16'h0000};
    tbl[5]  = '{5, 0, 0, 0, 0, 16'h0000, 0, 4'h0,  0, 16'h00CD, 16'hF002, 16'h0000};
    tbl[6]  = '{6, 0, 0, 1, 1, 16'h0100, 0, 4'h0,  0, 16'h0000, 16'hF002, 16'h0000};
    tbl[7]  = '{6, 0, 0, 0, 0, 16'h0000, 0, 4'h0,  0, 16'h0100, 16'hF002, 16'h0000};
    tbl[8]  = '{4, 0, 0, 0, 0, 16'h0000, 1, 4'hB,  0, 16'h0000, 16'hF002, 16'h0000};
    tbl[9]  = '{2, 0, 0, 0, 0, 16'h0000, 0, 4'h0,  0, 16'h0103, 16'hF002, 16'h0103};
    tbl[10] = '{7, 0, 0, 1, 0, 16'hFFFF, 0, 4'h0,  0, 16'h0000, 16'hF002, 16'h0103};
    tbl[11] = '{7, 3, 0, 0, 1, 16'h0000, 0, 4'h0,  1, 16'hFFFF, 16'hF002, 16'h0103};
    tbl[12] = '{7, 0, 0, 0, 0, 16'h0000, 0, 4'h0,  0, 16'h0001, 16'hF002, 16'h0103};
    tbl[13] = '{1, 0, 0, 1, 0, 16'h1235, 0, 4'h0,  0, 16'h0400, 16'hF002, 16'h0103};
    tbl[14] = '{1, 3, 1, 0, 1, 16'h0000, 0, 4'h0,  1, 16'h1234, 16'hF002, 16'h0103};
    tbl[15] = '{1, 0, 1, 0, 0, 16'h0000, 0, 4'h0,  0, 16'h0036, 16'hF002, 16'h0103};
    tbl[16] = '{2, 0, 0, 1, 0, 16'h0010, 1, 4'hF,  0, 16'h0103, 16'hF002, 16'h0103};
    tbl[17] = '{8, 1, 0, 0, 0, 16'h0000, 0, 4'h0,  1, 16'h0000, 16'hF002, 16'h0010};
    tbl[18] = '{0, 0, 0, 1, 0, 16'h3001, 0, 4'h0,  0, 16'hF002, 16'hF002, 16'h0010};
    tbl[19] = '{9, 2, 1, 0, 0, 16'h0000, 0, 4'h0,  1, 16'h0000, 16'h3000, 16'h0010};
    tbl[20] = '{2, 0, 0, 0, 1, 16'h0000, 1, 4'h1,  0, 16'h0010, 16'h3000, 16'h0010};
    tbl[21] = '{10, 0, 0, 0, 0, 16'h0000, 0, 4'h0, 0, 16'h0000, 16'h3000, 16'h0011};

    // Reset
    srst = 1'b1;
    drive(4, 0, 0, 0, 0, 16'h0000, 0, 4'h0);
    model_reset();
    #3;
    check("reset.pc", bus.pc, RST_PC);
    check("reset.sr", bus.sr, 16'h0000);
    check("reset.r4", bus.operand, 16'h0000);
    @(negedge clk);
    srst = 1'b0;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].n, tbl[i].a, tbl[i].bm, tbl[i].st, tbl[i].inc, tbl[i].wd,
            tbl[i].fwe, tbl[i].fin);
      #1;
      check($sformatf("v%0d.use_mem", i), {15'd0, bus.use_mem}, {15'd0, tbl[i].e_mem});
      if (tbl[i].e_mem)
        check($sformatf("v%0d.addr", i), bus.addr, tbl[i].e_val);
      else
        check($sformatf("v%0d.operand", i), bus.operand, tbl[i].e_val);
      check($sformatf("v%0d.is_const", i), {15'd0, bus.is_const}, 16'h0000);
      check($sformatf("v%0d.pc", i), bus.pc, tbl[i].e_pc);
      check($sformatf("v%0d.sr", i), bus.sr, tbl[i].e_sr);
      step();
    end

    // R2/R3 corner sequence
`ifdef REGFILE_CG_EN
    drive(3, 3, 1, 0, 0, 16'h0000, 0, 4'h0);
    #1;
    check("cg.r3_ff", bus.operand, 16'h00FF);
    check("cg.r3_is_const", {15'd0, bus.is_const}, 16'h0001);
    check("cg.r3_use_mem", {15'd0, bus.use_mem}, 16'h0000);
    step();
    drive(3, 0, 0, 1, 0, 16'h1234, 0, 4'h0);
    step();
    drive(3, 0, 0, 0, 0, 16'h0000, 0, 4'h0);
    #1;
    check("cg.r3_zero", bus.operand, 16'h0000);
    step();
    drive(2, 1, 0, 0, 0, 16'h0000, 0, 4'h0);
    #1;
    check("cg.abs_addr", bus.addr, 16'h0000);
    check("cg.abs_use_mem", {15'd0, bus.use_mem}, 16'h0001);
    check("cg.abs_is_const", {15'd0, bus.is_const}, 16'h0000);
    step();
    drive(2, 3, 0, 0, 1, 16'h0000, 0, 4'h0);
    #1;
    check("cg.r2_eight", bus.operand, 16'h0008);
    step();
    #1;
    check("cg.r2_no_inc", bus.sr, 16'h0011);
`else
    drive(3, 0, 0, 1, 0, 16'h1234, 0, 4'h0);
    step();
    drive(3, 0, 0, 0, 0, 16'h0000, 0, 4'h0);
    #1;
    check("nocg.r3_reg", bus.operand, 16'h1234);
    check("nocg.r3_is_const", {15'd0, bus.is_const}, 16'h0000);
    step();
    drive(2, 2, 0, 0, 0, 16'h0000, 0, 4'h0);
    #1;
    check("nocg.r2_addr", bus.addr, 16'h0011);
    check("nocg.r2_use_mem", {15'd0, bus.use_mem}, 16'h0001);
    step();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 16'($urandom),
            ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
      #1;
      check_model($sformatf("rnd%0d", i));
      step();
    end

    // Asynchronous reset in the middle of a cycle
    drive(4, 0, 0, 1, 0, 16'h5555, 0, 4'h0);
    step();
    drive(4, 0, 0, 0, 0, 16'h0000, 0, 4'h0);
    #1;
    check("mid.r4_before", bus.operand, 16'h5555);
    #1;
    srst = 1'b1;
    #1;
    check("mid.r4_after", bus.operand, 16'h0000);
    check("mid.pc_after", bus.pc, RST_PC);
    model_reset();
    @(negedge clk);
    srst = 1'b0;
    #1;
    check_model("post_reset");
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
